// File: rtl/mem_stage_lsu.sv
// rtl/mem_stage_lsu.sv - MEM-stage load/store unit for the 5-stage RV32I pipeline
// Issues one data-memory access per memory instruction and stalls the pipeline until it completes.
module mem_stage_lsu #(
   parameter int ADDR_W = 32
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_valid,
   input  logic              i_mem_read,
   input  logic              i_mem_write,
   input  logic [2:0]        i_funct3,
   input  logic [31:0]       i_alu_result,
   input  logic [31:0]       i_store_data,
   input  logic              i_reg_write,
   input  logic [4:0]        i_rd,
   output logic              o_dmem_req,
   output logic              o_dmem_we,
   output logic [ADDR_W-1:0] o_dmem_addr,
   output logic [31:0]       o_dmem_wdata,
   output logic [3:0]        o_dmem_wstrb,
   input  logic              i_dmem_ready,
   input  logic              i_dmem_rvalid,
   input  logic [31:0]       i_dmem_rdata,
   output logic              o_stall,
   output logic              o_mem_read,
   output logic              o_reg_write,
   output logic [4:0]        o_rd,
   output logic [31:0]       o_alu_result,
   output logic [31:0]       o_mem_data_out,
   output logic              o_exc
);

   localparam logic [2:0] F_B  = 3'b000;
   localparam logic [2:0] F_H  = 3'b001;
   localparam logic [2:0] F_W  = 3'b010;
   localparam logic [2:0] F_BU = 3'b100;
   localparam logic [2:0] F_HU = 3'b101;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t state, state_n;

   logic              memop;
   logic              misaligned;
   logic              illegal;
   logic              start;
   logic [3:0]        st_wstrb;
   logic [31:0]       st_wdata;
   logic [7:0]        ld_byte;
   logic [15:0]       ld_half;
   logic [31:0]       ld_data;

   logic [ADDR_W-3:0] req_addr;
   logic              req_we;
   logic [2:0]        req_funct3;
   logic [1:0]        req_off;
   logic [31:0]       req_wdata;
   logic [3:0]        req_wstrb;

   assign memop = i_valid & (i_mem_read | i_mem_write);

   always_comb begin
      misaligned = 1'b0;
      case (i_funct3)
         F_H, F_HU: misaligned = i_alu_result[0];
         F_W:       misaligned = |i_alu_result[1:0];
         default:   misaligned = 1'b0;
      endcase
      // Loads accept B/H/W/BU/HU; stores only B/H/W.
      illegal = (i_mem_read  & ((i_funct3 == 3'b011) | (i_funct3[2:1] == 2'b11)))
              | (i_mem_write & (i_funct3 >= 3'b011));
   end

   assign o_exc = (state == IDLE) & memop & (misaligned | illegal);
   assign start = (state == IDLE) & memop & ~(misaligned | illegal);

   always_comb begin
      st_wstrb = 4'b1111;
      st_wdata = i_store_data;
      case (i_funct3[1:0])
         2'b00: begin
            st_wstrb = 4'b0001 << i_alu_result[1:0];
            st_wdata = {4{i_store_data[7:0]}};
         end
         2'b01: begin
            st_wstrb = i_alu_result[1] ? 4'b1100 : 4'b0011;
            st_wdata = {2{i_store_data[15:0]}};
         end
         default: begin
            st_wstrb = 4'b1111;
            st_wdata = i_store_data;
         end
      endcase
   end

   always_comb begin
      ld_byte = i_dmem_rdata[{req_off, 3'b000} +: 8];
      ld_half = i_dmem_rdata[{req_off[1], 4'b0000} +: 16];
      case (req_funct3)
         F_B:     ld_data = {{24{ld_byte[7]}}, ld_byte};
         F_H:     ld_data = {{16{ld_half[15]}}, ld_half};
         F_BU:    ld_data = {24'd0, ld_byte};
         F_HU:    ld_data = {16'd0, ld_half};
         default: ld_data = i_dmem_rdata;
      endcase
   end

   always_comb begin
      state_n = state;
      o_stall = 1'b0;
      case (state)
         IDLE: begin
            o_stall = start;
            if (start) state_n = REQ;
         end
         REQ: begin
            o_stall = 1'b1;
            if (i_dmem_ready) state_n = req_we ? DONE : WAIT;
         end
         WAIT: begin
            o_stall = 1'b1;
            if (i_dmem_rvalid) state_n = DONE;
         end
         DONE: begin
            o_stall = 1'b0;
            state_n = IDLE;
         end
         default: begin
            o_stall = 1'b0;
            state_n = IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state          <= IDLE;
         req_addr       <= '0;
         req_we         <= 1'b0;
         req_funct3     <= 3'b000;
         req_off        <= 2'b00;
         req_wdata      <= 32'd0;
         req_wstrb      <= 4'b0000;
         o_mem_data_out <= 32'd0;
      end else begin
         state <= state_n;
         if (start) begin
            req_addr   <= i_alu_result[ADDR_W-1:2];
            req_we     <= i_mem_write;
            req_funct3 <= i_funct3;
            req_off    <= i_alu_result[1:0];
            req_wdata  <= st_wdata;
            req_wstrb  <= i_mem_write ? st_wstrb : 4'b0000;
         end
         if ((state == WAIT) && i_dmem_rvalid) o_mem_data_out <= ld_data;
      end
   end

   // Request fields come straight from the capture registers, so they cannot move while waiting for ready.
   assign o_dmem_req   = (state == REQ);
   assign o_dmem_we    = req_we;
   assign o_dmem_addr  = {req_addr, 2'b00};
   assign o_dmem_wdata = req_wdata;
   assign o_dmem_wstrb = req_wstrb;

   assign o_mem_read   = i_mem_read;
   assign o_reg_write  = i_reg_write & i_valid & ~o_exc;
   assign o_rd         = i_rd;
   assign o_alu_result = i_alu_result;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb/tb_mem_stage_lsu.sv - testbench for mem_stage_lsu
// Acts as EX/MEM register plus data memory; expectations come from a reference model of the access rules.
module tb_mem_stage_lsu;

   logic        i_clk = 1'b0;
   logic        i_rst;
   logic        i_valid;
   logic        i_mem_read;
   logic        i_mem_write;
   logic [2:0]  i_funct3;
   logic [31:0] i_alu_result;
   logic [31:0] i_store_data;
   logic        i_reg_write;
   logic [4:0]  i_rd;
   logic        o_dmem_req;
   logic        o_dmem_we;
   logic [31:0] o_dmem_addr;
   logic [31:0] o_dmem_wdata;
   logic [3:0]  o_dmem_wstrb;
   logic        i_dmem_ready;
   logic        i_dmem_rvalid;
   logic [31:0] i_dmem_rdata;
   logic        o_stall;
   logic        o_mem_read;
   logic        o_reg_write;
   logic [4:0]  o_rd;
   logic [31:0] o_alu_result;
   logic [31:0] o_mem_data_out;
   logic        o_exc;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] exp_mdo  = 32'd0;

   mem_stage_lsu #(.ADDR_W(32)) dut (
      .i_clk          (i_clk),
      .i_rst          (i_rst),
      .i_valid        (i_valid),
      .i_mem_read     (i_mem_read),
      .i_mem_write    (i_mem_write),
      .i_funct3       (i_funct3),
      .i_alu_result   (i_alu_result),
      .i_store_data   (i_store_data),
      .i_reg_write    (i_reg_write),
      .i_rd           (i_rd),
      .o_dmem_req     (o_dmem_req),
      .o_dmem_we      (o_dmem_we),
      .o_dmem_addr    (o_dmem_addr),
      .o_dmem_wdata   (o_dmem_wdata),
      .o_dmem_wstrb   (o_dmem_wstrb),
      .i_dmem_ready   (i_dmem_ready),
      .i_dmem_rvalid  (i_dmem_rvalid),
      .i_dmem_rdata   (i_dmem_rdata),
      .o_stall        (o_stall),
      .o_mem_read     (o_mem_read),
      .o_reg_write    (o_reg_write),
      .o_rd           (o_rd),
      .o_alu_result   (o_alu_result),
      .o_mem_data_out (o_mem_data_out),
      .o_exc          (o_exc)
   );

   always #5 i_clk = ~i_clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
      n_checks++;
      assert (obs === want) else begin
         n_fail++;
         $error("FAIL %s: observed %h, expected %h", tag, obs, want);
      end
   endtask

   function automatic logic model_exc(input logic r, input logic w, input logic [2:0] f3,
                                      input logic [31:0] a);
      int   off;
      logic bad;
      off = a % 4;
      bad = 1'b0;
      if ((f3 == 3'd1 || f3 == 3'd5) && (off % 2) != 0) bad = 1'b1;
      if (f3 == 3'd2 && off != 0) bad = 1'b1;
      if (r && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) bad = 1'b1;
      if (w && f3 >= 3'd3) bad = 1'b1;
      return bad;
   endfunction

   function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                              input logic [31:0] rdata);
      int          off;
      logic [31:0] v;
      off = a % 4;
      if (f3 == 3'd0 || f3 == 3'd4) begin
         v = (rdata >> (8 * off)) & 32'hFF;
         if (f3 == 3'd0 && v >= 32'd128) v = v - 32'd256;
      end else if (f3 == 3'd1 || f3 == 3'd5) begin
         v = (rdata >> (16 * (off / 2))) & 32'hFFFF;
         if (f3 == 3'd1 && v >= 32'd32768) v = v - 32'd65536;
      end else begin
         v = rdata;
      end
      return v;
   endfunction

   function automatic logic [31:0] model_wstrb(input logic [2:0] f3, input logic [31:0] a);
      int off;
      off = a % 4;
      if (f3 == 3'd0) return 32'd1 << off;
      if (f3 == 3'd1) return (off >= 2) ? 32'd12 : 32'd3;
      return 32'd15;
   endfunction

   function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] sd);
      if (f3 == 3'd0) return (sd & 32'hFF) * 32'h01010101;
      if (f3 == 3'd1) return (sd & 32'hFFFF) * 32'h00010001;
      return sd;
   endfunction

   // Called just after a rising edge; returns just after the edge on which the instruction leaves MEM.
   task automatic run_instr(input logic v, input logic r, input logic w, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] sd, input logic rw,
                            input logic [4:0] rdn, input int rdy_dly, input int rv_dly,
                            input logic [31:0] rdata);
      logic memop;
      logic exc;
      int   stalls;
      i_valid = v; i_mem_read = r; i_mem_write = w; i_funct3 = f3;
      i_alu_result = addr; i_store_data = sd; i_reg_write = rw; i_rd = rdn;
      memop  = v & (r | w);
      exc    = memop & model_exc(r, w, f3, addr);
      stalls = 0;
      i_dmem_ready  = 1'($urandom_range(0, 1));
      i_dmem_rvalid = 1'($urandom_range(0, 1));
      i_dmem_rdata  = $urandom;
      @(negedge i_clk);
      chk("idle_exc", o_exc, exc);
      chk("idle_req", o_dmem_req, 0);
      chk("idle_stall", o_stall, memop & ~exc);
      chk("idle_regw", o_reg_write, rw & v & ~exc);
      chk("pass_rd", o_rd, rdn);
      chk("pass_alu", o_alu_result, addr);
      chk("pass_mread", o_mem_read, r);
      chk("mdo_hold", o_mem_data_out, exp_mdo);
      if (o_stall === 1'b1) stalls++;
      @(posedge i_clk); #1;
      if (memop && !exc) begin
         for (int k = 0; k <= rdy_dly; k++) begin
            i_dmem_ready  = (k == rdy_dly);
            i_dmem_rvalid = 1'($urandom_range(0, 1));
            i_dmem_rdata  = $urandom;
            @(negedge i_clk);
            chk("req_valid", o_dmem_req, 1);
            chk("req_we", o_dmem_we, w);
            chk("req_addr", o_dmem_addr, addr & 32'hFFFFFFFC);
            chk("req_wstrb", o_dmem_wstrb, w ? model_wstrb(f3, addr) : 32'd0);
            if (w) chk("req_wdata", o_dmem_wdata, model_wdata(f3, sd));
            chk("req_exc", o_exc, 0);
            if (o_stall === 1'b1) stalls++;
            @(posedge i_clk); #1;
         end
         if (!w) begin
            for (int k = 0; k <= rv_dly; k++) begin
               i_dmem_ready  = 1'($urandom_range(0, 1));
               i_dmem_rvalid = (k == rv_dly);
               i_dmem_rdata  = (k == rv_dly) ? rdata : $urandom;
               @(negedge i_clk);
               chk("wait_req", o_dmem_req, 0);
               if (o_stall === 1'b1) stalls++;
               @(posedge i_clk); #1;
            end
            exp_mdo = model_load(f3, addr, rdata);
         end
         i_dmem_ready  = 1'b0;
         i_dmem_rvalid = 1'b0;
         @(negedge i_clk);
         chk("done_stall", o_stall, 0);
         chk("done_req", o_dmem_req, 0);
         chk("done_mdo", o_mem_data_out, exp_mdo);
         chk("done_regw", o_reg_write, rw);
         @(posedge i_clk); #1;
         chk("stall_cycles", stalls, w ? 2 + rdy_dly : 3 + rdy_dly + rv_dly);
      end
      i_dmem_ready  = 1'b0;
      i_dmem_rvalid = 1'b0;
   endtask

   initial begin
      logic [2:0]  f3;
      logic [31:0] a;
      int          kind;
      i_rst = 1'b1; i_valid = 1'b0; i_mem_read = 1'b0; i_mem_write = 1'b0;
      i_funct3 = 3'd0; i_alu_result = 32'd0; i_store_data = 32'd0;
      i_reg_write = 1'b0; i_rd = 5'd0;
      i_dmem_ready = 1'b0; i_dmem_rvalid = 1'b0; i_dmem_rdata = 32'd0;
      repeat (2) @(posedge i_clk);
      #1 i_rst = 1'b0;
      @(negedge i_clk);
      chk("rst_req", o_dmem_req, 0);
      chk("rst_we", o_dmem_we, 0);
      chk("rst_addr", o_dmem_addr, 0);
      chk("rst_wdata", o_dmem_wdata, 0);
      chk("rst_wstrb", o_dmem_wstrb, 0);
      chk("rst_mdo", o_mem_data_out, 0);
      chk("rst_stall", o_stall, 0);
      @(posedge i_clk); #1;

      run_instr(1, 1, 0, 3'd2, 32'h100, 32'd0, 1, 5'd1, 0, 0, 32'hDEADBEEF);
      chk("lw_value", o_mem_data_out, 32'hDEADBEEF);
      run_instr(1, 1, 0, 3'd0, 32'h103, 32'd0, 1, 5'd2, 0, 0, 32'h80FF0000);
      chk("lb_value", o_mem_data_out, 32'hFFFFFF80);
      run_instr(1, 1, 0, 3'd4, 32'h103, 32'd0, 1, 5'd2, 0, 0, 32'h80FF0000);
      chk("lbu_value", o_mem_data_out, 32'h00000080);
      run_instr(1, 1, 0, 3'd5, 32'h102, 32'd0, 1, 5'd2, 0, 0, 32'h80FF0000);
      chk("lhu_value", o_mem_data_out, 32'h000080FF);
      run_instr(1, 0, 1, 3'd0, 32'h201, 32'h000000AB, 0, 5'd0, 3, 0, 32'd0);
      chk("sb_keeps_mdo", o_mem_data_out, 32'h000080FF);
      run_instr(1, 1, 0, 3'd2, 32'h102, 32'd0, 1, 5'd4, 0, 0, 32'd0);
      run_instr(1, 0, 0, 3'd0, 32'h00000055, 32'd0, 1, 5'd5, 0, 0, 32'd0);
      run_instr(1, 0, 1, 3'd2, 32'h300, 32'h12345678, 0, 5'd0, 0, 0, 32'd0);
      run_instr(1, 1, 0, 3'd1, 32'h302, 32'd0, 1, 5'd6, 0, 0, 32'h8001_7FFF);
      chk("lh_value", o_mem_data_out, 32'hFFFF8001);

      for (int n = 0; n < 250; n++) begin
         kind = $urandom_range(0, 9);
         f3 = 3'($urandom_range(0, 2));
         if ($urandom_range(0, 2) == 0) f3[2] = (f3 != 3'd2);
         if ($urandom_range(0, 15) == 0) f3 = 3'($urandom_range(0, 7));
         a = $urandom;
         if ($urandom_range(0, 7) != 0) begin
            if (f3[1:0] == 2'b01) a[0] = 1'b0;
            if (f3[1:0] == 2'b10) a[1:0] = 2'b00;
         end
         if (kind < 2)
            run_instr(1, 0, 0, 3'($urandom_range(0, 7)), $urandom, $urandom, 1'($urandom_range(0, 1)),
                      5'($urandom), 0, 0, 32'd0);
         else if (kind < 6)
            run_instr(1, 1, 0, f3, a, $urandom, 1, 5'($urandom), $urandom_range(0, 3),
                      $urandom_range(0, 2), $urandom);
         else if (kind < 9)
            run_instr(1, 0, 1, f3 & 3'b011, a, $urandom, 0, 5'($urandom), $urandom_range(0, 3), 0, 32'd0);
         else
            run_instr(0, 1, 0, f3, a, $urandom, 1, 5'($urandom), 0, 0, 32'd0);
      end

      run_instr(1, 1, 0, 3'd2, 32'h500, 32'd0, 1, 5'd7, 0, 0, 32'hA5A5_5A5A);
      i_valid = 1'b1; i_mem_read = 1'b1; i_mem_write = 1'b0; i_funct3 = 3'd2;
      i_alu_result = 32'h400; i_reg_write = 1'b1; i_rd = 5'd3;
      i_dmem_ready = 1'b1; i_dmem_rvalid = 1'b0;
      @(posedge i_clk); #1;
      @(posedge i_clk); #1;
      i_dmem_ready = 1'b0; i_rst = 1'b1; i_dmem_rvalid = 1'b1; i_dmem_rdata = 32'h12345678;
      @(negedge i_clk);
      chk("wait_before_rst", o_stall, 1);
      @(posedge i_clk); #1;
      i_rst = 1'b0; i_valid = 1'b0; i_mem_read = 1'b0;
      i_dmem_rvalid = 1'b1; i_dmem_rdata = 32'hCAFEF00D;
      @(negedge i_clk);
      chk("rst_wait_req", o_dmem_req, 0);
      chk("rst_wait_stall", o_stall, 0);
      chk("rst_wait_mdo", o_mem_data_out, 0);
      @(posedge i_clk); #1;
      i_dmem_rvalid = 1'b0;
      @(negedge i_clk);
      chk("late_rvalid_mdo", o_mem_data_out, 0);
      chk("late_rvalid_req", o_dmem_req, 0);
      chk("late_rvalid_stall", o_stall, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
